spi_boot_loader: RTL and testbench
==================================

SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 Parameter WORD_COUNT, default 1024: number of 32-bit words copied per boot; legal range 1..65536.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: destination byte address of the first word on the rib write port.
REQ-004 Parameter FLASH_ADDR, default 24'h000000: flash byte address where the image starts.
REQ-005 clk  in  1  single system clock (50 MHz); all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start_i  in  1  one-cycle pulse that begins a copy.
REQ-008 spi_cs_n_o  out  1  flash chip select, active-low.
REQ-009 spi_sclk_o  out  1  SPI clock, mode 0.
REQ-010 spi_mosi_o  out  1  serial data to flash.
REQ-011 spi_miso_i  in  1  serial data from flash.
REQ-012 rib_wr_req_o  out  1  bus-ownership request to the rib master port; high for the whole copy.
REQ-013 mem_wr_en_o  out  1  one-cycle word-write strobe.
REQ-014 mem_wr_addr_o  out  32  word destination byte address.
REQ-015 mem_wr_data_o  out  32  word data.
REQ-016 busy_o  out  1  high from the cycle after an accepted start until DONE.
REQ-017 done_o  out  1  level, high in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE, CMD, DATA, WRITE and DONE.
REQ-019 IDLE or DONE, start_i=1: SHALL go to CMD next cycle; drive cs_n low; load the shift register with {8'h03, FLASH_ADDR}; clear the word counter; clear done_o.
REQ-020 CMD SHALL shift the 32 bits out MSB first; after bit 31 it SHALL go to DATA.
REQ-021 SPI mode 0: SCLK SHALL idle low, MOSI SHALL change only when SCLK falls, MISO SHALL be sampled on the clk edge where SCLK rises, and each SCLK phase SHALL last exactly CLK_DIV clk cycles.
REQ-022 DATA SHALL receive 32 bits MSB-first per byte; bytes SHALL be assembled little-endian (first byte -> data[7:0], fourth -> data[31:24]); after the 32nd bit the FSM SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly 1 clk, with mem_wr_en_o=1, mem_wr_addr_o=BASE_ADDR+4*count, and mem_wr_data_o=assembled word.
REQ-024 After WRITE, the FSM SHALL return to DATA if count+1<WORD_COUNT; otherwise it SHALL go to DONE.
REQ-025 SCLK SHALL remain low and cs_n low during WRITE (burst read continues).
REQ-026 On entering DONE, cs_n SHALL go high and rib_wr_req_o SHALL drop in the same cycle.
REQ-027 start_i while in CMD, DATA or WRITE SHALL be ignored.
REQ-028 rib_wr_req_o SHALL rise in the same cycle as busy_o.
REQ-029 The address adder SHALL be 32-bit modulo; the word counter SHALL be 17 bits and never wrap within one copy.
REQ-030 mem_wr_addr_o and mem_wr_data_o SHALL hold their last values outside WRITE.
REQ-031 mem_wr_en_o SHALL never assert outside WRITE.

Reset
REQ-032 While rst_n=0, outputs SHALL be asynchronously forced to: state IDLE, spi_cs_n_o=1, spi_sclk_o=0, spi_mosi_o=0, rib_wr_req_o=0, mem_wr_en_o=0, mem_wr_addr_o=0, mem_wr_data_o=0, busy_o=0, done_o=0.
REQ-033 Reset mid-copy SHALL abort without a partial write; after release the block SHALL wait in IDLE for a new start_i.

Structure
REQ-034 The constants for the flash read opcode (8'h03) and the state encodings SHALL live in the shared defines package; bus widths SHALL reuse INST_ADDR_BUS and INST_DATA_BUS.
REQ-035 The SCLK divider and bit shifter SHALL be one sub-module, spi_shifter (start, 32-bit tx, 32-bit rx, done pulse); the FSM, counters and rib interface SHALL stay in spi_boot_loader.

Verification
REQ-036 Check 1: WORD_COUNT=2, flash bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0x0 and 0x88776655 @0x4, then done_o=1 and cs_n=1.
REQ-037 Check 2: CLK_DIV=3 -> every SCLK high and low phase measures 3 clk, and MOSI carries 0x03000000 during the first 32 SCLKs.
REQ-038 Check 3: start_i pulsed in the middle of DATA -> no restart, and the write sequence is unchanged.
REQ-039 Check 4: rst_n low in the middle of word 1 -> cs_n=1 immediately and no mem_wr_en_o; a following start copies from word 0.
REQ-040 Check 5: start_i in DONE -> a second full copy runs with identical data, and done_o clears for its duration.
REQ-041 Check 6: BASE_ADDR=32'hFFFF_FFFC with WORD_COUNT=2 -> the second write lands at 0x0 (modulo wrap).

Source files
------------

// File: rtl/spi_boot_loader_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash boot loader.
// Latency: n/a (package only).
// Backpressure: n/a.
package spi_boot_loader_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_DATA_BUS = 32;

   // Serial-flash "read data" opcode; continuous read until cs_n rises
   localparam logic [7:0] FLASH_READ_OP = 8'h03;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // The shifter collects the four flash bytes first-byte-in-MSB; the image is
   // little-endian, so the first byte received becomes bits [7:0].
   function automatic logic [INST_DATA_BUS-1:0] le_word(input logic [31:0] rx);
      return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
   endfunction

endpackage

// File: rtl/spi_boot_loader_if.sv
// Flash pins plus the rib write port of the boot loader, bundled as one bus.
// Latency: n/a (wiring only).
// Backpressure: none; the memory side must accept every write strobe.
// Ports: spi_cs_n_o/spi_sclk_o/spi_mosi_o/spi_miso_i (flash), rib_wr_req_o,
//        mem_wr_en_o/mem_wr_addr_o/mem_wr_data_o (rib write port).
interface spi_boot_loader_if;
   import spi_boot_loader_pkg::*;

   logic                     spi_cs_n_o;
   logic                     spi_sclk_o;
   logic                     spi_mosi_o;
   logic                     spi_miso_i;
   logic                     rib_wr_req_o;
   logic                     mem_wr_en_o;
   logic [INST_ADDR_BUS-1:0] mem_wr_addr_o;
   logic [INST_DATA_BUS-1:0] mem_wr_data_o;

   modport master (
      output spi_cs_n_o, spi_sclk_o, spi_mosi_o,
      input  spi_miso_i,
      output rib_wr_req_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
   );

   modport slave (
      input  spi_cs_n_o, spi_sclk_o, spi_mosi_o,
      output spi_miso_i,
      input  rib_wr_req_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
   );

endinterface

// File: rtl/spi_shifter.sv
// SPI mode-0 SCLK divider and 32-bit full-duplex shifter, MSB first.
// Latency: 64*CLK_DIV clk from start to the done pulse.
// Backpressure: none; start reloads immediately, caller starts only when idle.
// Ports: clk, rst_n, start, tx[31:0], rx[31:0], done (1-clk pulse), sclk, mosi, miso.
module spi_shifter #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] tx,
   output logic [31:0] rx,
   output logic        done,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic        active;
   logic [7:0]  div_cnt;
   logic [4:0]  bit_cnt;
   logic [30:0] tx_sh;    // bits still to be sent after the one on mosi

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sh   <= '0;
         rx      <= '0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // First bit is presented while SCLK is still low, ahead of the first rise
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= tx[30:0];
            mosi    <= tx[31];
            sclk    <= 1'b0;
         end else if (active) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               sclk    <= ~sclk;
               if (!sclk) begin
                  // rising edge: sample the flash
                  rx <= {rx[30:0], miso};
               end else begin
                  // falling edge: advance mosi; after the last bit zeros drain out
                  tx_sh   <= {tx_sh[29:0], 1'b0};
                  mosi    <= tx_sh[30];
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd31) begin
                     active <= 1'b0;
                     done   <= 1'b1;
                  end
               end
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_boot_loader.sv
// Copies WORD_COUNT little-endian words from SPI flash into memory over the rib write port.
// Latency: ~64*CLK_DIV*(WORD_COUNT+1) + WORD_COUNT + 2 clk from start_i to done_o.
// Backpressure: none; one write strobe per word, start_i ignored while busy.
// Ports: clk, rst_n, start_i, busy_o, done_o, bus (flash pins + rib write port).
module spi_boot_loader
   import spi_boot_loader_pkg::*;
#(
   parameter int          WORD_COUNT = 1024,
   parameter int          CLK_DIV    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [23:0] FLASH_ADDR = 24'h000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   spi_boot_loader_if.master bus
);

   state_t state, state_nxt;

   logic [16:0]              count;
   logic [16:0]              count_inc;
   logic                     last_word;
   logic                     sh_start;
   logic [31:0]              sh_tx;
   logic [31:0]              sh_rx;
   logic                     sh_done;
   logic                     sclk;
   logic                     mosi;
   logic [INST_ADDR_BUS-1:0] wr_addr;
   logic [INST_DATA_BUS-1:0] wr_data;
   logic                     active;

   assign count_inc = count + 17'd1;
   assign last_word = (count_inc >= 17'(WORD_COUNT));

   spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (sh_start),
      .tx    (sh_tx),
      .rx    (sh_rx),
      .done  (sh_done),
      .sclk  (sclk),
      .mosi  (mosi),
      .miso  (bus.spi_miso_i)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sh_start  = 1'b0;
      sh_tx     = '0;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               state_nxt = CMD;
               sh_start  = 1'b1;
               sh_tx     = {FLASH_READ_OP, FLASH_ADDR};
            end
         end
         CMD: begin
            if (sh_done) begin
               state_nxt = DATA;
               sh_start  = 1'b1;
            end
         end
         DATA: begin
            if (sh_done) state_nxt = WRITE;
         end
         WRITE: begin
            // cs_n stays low across WRITE so the flash keeps streaming
            if (last_word) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DATA;
               sh_start  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         if ((state == IDLE || state == DONE) && start_i) count <= '0;
         // Address/data load on entry to WRITE and hold until the next word
         if (state == DATA && sh_done) begin
            wr_addr <= BASE_ADDR + {13'd0, count, 2'b00};
            wr_data <= le_word(sh_rx);
         end
         if (state == WRITE) count <= count_inc;
      end
   end

   // Outputs decode straight from state so reset forces them asynchronously
   assign active           = (state == CMD) || (state == DATA) || (state == WRITE);
   assign busy_o           = active;
   assign done_o           = (state == DONE);
   assign bus.spi_cs_n_o   = ~active;
   assign bus.rib_wr_req_o = active;
   assign bus.spi_sclk_o   = sclk;
   assign bus.spi_mosi_o   = mosi;
   assign bus.mem_wr_en_o  = (state == WRITE);
   assign bus.mem_wr_addr_o = wr_addr;
   assign bus.mem_wr_data_o = wr_data;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: two instances (CLK_DIV=2 base 0, CLK_DIV=3 base FFFF_FFFC).
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_boot_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n  = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0, done0, busy1, done1;

   spi_boot_loader_if bus0();
   spi_boot_loader_if bus1();

   spi_boot_loader #(.WORD_COUNT(2), .CLK_DIV(2), .BASE_ADDR(32'h0000_0000),
                     .FLASH_ADDR(24'h000000)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0), .bus(bus0));

   spi_boot_loader #(.WORD_COUNT(2), .CLK_DIV(3), .BASE_ADDR(32'hFFFF_FFFC),
                     .FLASH_ADDR(24'h000000)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1), .bus(bus1));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Flash image at address 0
   logic [7:0] img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   function automatic logic fbit(input int k);
      if (k < 0 || k >= 64) return 1'b0;
      return img[k/8][7-(k%8)];
   endfunction

   // Flash models: count SCLK rises since cs_n fell; first 32 carry the command
   int          f0_rise = 0;
   int          f1_rise = 0;
   logic [31:0] cmd0 = '0;
   logic [31:0] cmd1 = '0;

   always @(posedge bus0.spi_sclk_o or posedge bus0.spi_cs_n_o) begin
      if (bus0.spi_cs_n_o) f0_rise <= 0;
      else begin
         if (f0_rise < 32) cmd0 <= {cmd0[30:0], bus0.spi_mosi_o};
         f0_rise <= f0_rise + 1;
      end
   end

   always @(posedge bus1.spi_sclk_o or posedge bus1.spi_cs_n_o) begin
      if (bus1.spi_cs_n_o) f1_rise <= 0;
      else begin
         if (f1_rise < 32) cmd1 <= {cmd1[30:0], bus1.spi_mosi_o};
         f1_rise <= f1_rise + 1;
      end
   end

   assign bus0.spi_miso_i = fbit(f0_rise - 32);
   assign bus1.spi_miso_i = fbit(f1_rise - 32);

   // Write capture
   logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
   always @(negedge clk) begin
      if (bus0.mem_wr_en_o) begin wa0.push_back(bus0.mem_wr_addr_o); wd0.push_back(bus0.mem_wr_data_o); end
      if (bus1.mem_wr_en_o) begin wa1.push_back(bus1.mem_wr_addr_o); wd1.push_back(bus1.mem_wr_data_o); end
   end

   // SCLK phase lengths of dut1 during the command (first 32 SCLKs)
   int   run1 = 0;
   int   nr1  = 0;
   int   ph1  = 0;
   logic prev1 = 1'b0;
   always @(negedge clk) begin
      if (bus1.spi_cs_n_o) begin
         nr1  = 0;
         run1 = 0;
      end else if (bus1.spi_sclk_o != prev1) begin
         if (!prev1 && nr1 >= 1 && nr1 < 32) begin check("sclk_low_phase", 32'(run1), 32'd3); ph1++; end
         if (prev1 && nr1 <= 32) begin check("sclk_high_phase", 32'(run1), 32'd3); ph1++; end
         if (!prev1) nr1++;
         run1 = 1;
      end else begin
         run1++;
      end
      prev1 = bus1.spi_sclk_o;
   end

   typedef struct {
      int          dut;
      int          idx;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_vec_t;
   wr_vec_t tbl [4];

   task automatic clear_q();
      wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
   endtask

   task automatic check_writes(input int d, input string tag);
      int n = 0;
      int sz;
      for (int i = 0; i < 4; i++) if (tbl[i].dut == d) n++;
      sz = (d == 0) ? wa0.size() : wa1.size();
      check({tag, "_nwrites"}, 32'(sz), 32'(n));
      for (int i = 0; i < 4; i++) begin
         if (tbl[i].dut == d && tbl[i].idx < sz) begin
            check({tag, "_addr"}, (d == 0) ? wa0[tbl[i].idx] : wa1[tbl[i].idx], tbl[i].addr);
            check({tag, "_data"}, (d == 0) ? wd0[tbl[i].idx] : wd1[tbl[i].idx], tbl[i].data);
         end
      end
   endtask

   task automatic pulse(input int d);
      @(negedge clk);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int max, input string tag);
      logic dn = 1'b0;
      for (int i = 0; i < max && !dn; i++) begin
         @(negedge clk);
         dn = (d == 0) ? done0 : done1;
      end
      check({tag, "_done_seen"}, 32'(dn), 32'd1);
   endtask

   task automatic wait_rise0(input int n, input int max, input string tag);
      for (int i = 0; i < max && f0_rise < n; i++) @(negedge clk);
      check({tag, "_reached_bit"}, 32'(f0_rise >= n), 32'd1);
   endtask

   initial begin
      tbl[0] = '{0, 0, 32'h0000_0000, 32'h4433_2211};
      tbl[1] = '{0, 1, 32'h0000_0004, 32'h8877_6655};
      tbl[2] = '{1, 0, 32'hFFFF_FFFC, 32'h4433_2211};
      tbl[3] = '{1, 1, 32'h0000_0000, 32'h8877_6655};

      // Reset state
      #3;
      check("rst_cs_n",  32'(bus0.spi_cs_n_o),   32'd1);
      check("rst_sclk",  32'(bus0.spi_sclk_o),   32'd0);
      check("rst_mosi",  32'(bus0.spi_mosi_o),   32'd0);
      check("rst_req",   32'(bus0.rib_wr_req_o), 32'd0);
      check("rst_wr_en", 32'(bus0.mem_wr_en_o),  32'd0);
      check("rst_addr",  bus0.mem_wr_addr_o,     32'd0);
      check("rst_data",  bus0.mem_wr_data_o,     32'd0);
      check("rst_busy",  32'(busy0),             32'd0);
      check("rst_done",  32'(done0),             32'd0);
      #20;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_cs_n", 32'(bus0.spi_cs_n_o), 32'd1);

      // Two-word copy
      clear_q();
      pulse(0);
      check("start_busy", 32'(busy0),             32'd1);
      check("start_req",  32'(bus0.rib_wr_req_o), 32'd1);
      check("start_cs_n", 32'(bus0.spi_cs_n_o),   32'd0);
      wait_done(0, 2000, "copy1");
      check("done_cs_n", 32'(bus0.spi_cs_n_o),   32'd1);
      check("done_req",  32'(bus0.rib_wr_req_o), 32'd0);
      check("done_busy", 32'(busy0),             32'd0);
      check("done_sclk", 32'(bus0.spi_sclk_o),   32'd0);
      check_writes(0, "copy1");
      check("copy1_cmd", cmd0, 32'h0300_0000);
      check("hold_addr", bus0.mem_wr_addr_o, 32'h0000_0004);
      check("hold_data", bus0.mem_wr_data_o, 32'h8877_6655);

      // Restart from DONE
      repeat (5) @(negedge clk);
      clear_q();
      pulse(0);
      check("redo_done_clr", 32'(done0), 32'd0);
      check("redo_busy",     32'(busy0), 32'd1);
      wait_done(0, 2000, "copy2");
      check_writes(0, "copy2");

      // start_i in the middle of DATA is ignored
      repeat (5) @(negedge clk);
      clear_q();
      pulse(0);
      wait_rise0(48, 1000, "mid_data");
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      check("ign_cs_n", 32'(bus0.spi_cs_n_o), 32'd0);
      check("ign_rise", 32'(f0_rise >= 48),  32'd1);
      wait_done(0, 2000, "ign");
      check_writes(0, "ign");

      // Reset in the middle of word 1
      repeat (5) @(negedge clk);
      clear_q();
      pulse(0);
      wait_rise0(80, 1000, "mid_word1");
      clear_q();
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("abort_cs_n",  32'(bus0.spi_cs_n_o),  32'd1);
      check("abort_busy",  32'(busy0),            32'd0);
      check("abort_wr_en", 32'(bus0.mem_wr_en_o), 32'd0);
      check("abort_sclk",  32'(bus0.spi_sclk_o),  32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_nwrites", 32'(wa0.size()),       32'd0);
      check("abort_idle",    32'(bus0.spi_cs_n_o),  32'd1);
      check("abort_done",    32'(done0),            32'd0);
      pulse(0);
      wait_done(0, 2000, "after_rst");
      check_writes(0, "after_rst");

      // CLK_DIV=3 phases, command on MOSI, address wrap
      clear_q();
      pulse(1);
      wait_done(1, 3000, "div3");
      check("div3_cmd", cmd1, 32'h0300_0000);
      check("div3_phases_seen", 32'(ph1), 32'd63);
      check_writes(1, "wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
